fp_mult_arbiter: RTL and testbench

FP_MULT_ARBITER -- requirements
Module: fp_mult_arbiter

---
 rtl/fp_mult_arbiter.sv | 119 +++++++++++
 tb/tb_fp_mult_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter: two-requester front end for a shared, LATENCY-deep fp_mult core.
// Grants are combinational. A {valid, id} tag pipeline tracks each issued
// operation so the core's result can be steered back to its owner.
// Optional build macro FPM_ARB_FIXED_PRIO_EN: requester 0 always wins
// contention and the round-robin state is dropped. Without it, arbitration
// is round-robin.
module fp_mult_arbiter #(
  parameter int unsigned LATENCY = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  input  logic        hold,
  output logic        mult_clk_en,
  output logic [31:0] mult_dataa,
  output logic [31:0] mult_datab,
  input  logic [31:0] mult_result,
  input  logic [3:0]  mult_status,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] res,
  output logic [3:0]  res_status,
  output logic        busy
);

  localparam int unsigned TAIL = LATENCY - 1;

  // Tag pipeline: one entry per core stage, aligned with the core's data path.
  logic [LATENCY-1:0] tag_valid;
  logic [LATENCY-1:0] tag_id;
  logic               issue;

`ifndef FPM_ARB_FIXED_PRIO_EN
  // Index of the most recent grant; the other requester wins the next tie.
  logic last;
`endif

  // Arbitration: at most one grant per cycle, none while frozen or in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset && !hold) begin
      if (req0 && req1) begin
`ifdef FPM_ARB_FIXED_PRIO_EN
        gnt0 = 1'b1;
`else
        if (last) gnt0 = 1'b1;
        else      gnt1 = 1'b1;
`endif
      end else if (req0) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign issue = gnt0 | gnt1;

  // Operand mux: requester 0 is the idle default.
  always_comb begin
    mult_dataa = a0;
    mult_datab = b0;
    if (gnt1) begin
      mult_dataa = a1;
      mult_datab = b1;
    end
  end

  assign mult_clk_en = ~hold;

`ifndef FPM_ARB_FIXED_PRIO_EN
  // Round-robin state: reset favours requester 0, update only on a grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      last <= 1'b1;
    end else if (issue) begin
      last <= gnt1;
    end
  end
`endif

  // Tag shift register, frozen together with the core while hold is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid <= '0;
      tag_id    <= '0;
    end else if (!hold) begin
      for (int unsigned i = TAIL; i > 0; i--) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
      tag_valid[0] <= issue;
      tag_id[0]    <= gnt1;
    end
  end

  // Result steering: the tail tag selects the owner; data passes straight through.
  always_comb begin
    rvalid0 = 1'b0;
    rvalid1 = 1'b0;
    if (!reset && !hold && tag_valid[TAIL]) begin
      rvalid0 = ~tag_id[TAIL];
      rvalid1 = tag_id[TAIL];
    end
  end

  assign res        = mult_result;
  assign res_status = mult_status;
  assign busy       = |tag_valid;

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Bench for fp_mult_arbiter with a behavioural fp_mult core model and a
// result scoreboard keyed on issue order, owner and expected arrival cycle.
module tb_fp_mult_arbiter;

  localparam int unsigned LATENCY = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, hold;
  logic [31:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, mult_clk_en;
  logic [31:0] mult_dataa, mult_datab, mult_result, res;
  logic [3:0]  mult_status, res_status;
  logic        rvalid0, rvalid1, busy;

  int passed = 0;
  int total  = 0;

  fp_mult_arbiter #(.LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .hold(hold), .mult_clk_en(mult_clk_en),
    .mult_dataa(mult_dataa), .mult_datab(mult_datab),
    .mult_result(mult_result), .mult_status(mult_status),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .res(res), .res_status(res_status),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Simplified single-precision multiply: flush denormals, truncate mantissa.
  // Returns {status[3:0], result[31:0]}, status = {nan, zero, underflow, overflow}.
  function automatic logic [35:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    logic [7:0] ea, eb;
    logic [22:0] ma, mb, m;
    logic [47:0] p;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    int e;
    s = a[31] ^ b[31];
    ea = a[30:23]; eb = b[30:23]; ma = a[22:0]; mb = b[22:0];
    a_nan = (ea == 8'hFF) && (ma != 0); b_nan = (eb == 8'hFF) && (mb != 0);
    a_inf = (ea == 8'hFF) && (ma == 0); b_inf = (eb == 8'hFF) && (mb == 0);
    a_zero = (ea == 8'h00); b_zero = (eb == 8'h00);
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
      return {4'b1000, 32'h7FC00000};
    if (a_inf || b_inf) return {4'b0000, s, 8'hFF, 23'h0};
    if (a_zero || b_zero) return {4'b0100, s, 31'h0};
    p = 48'({1'b1, ma}) * 48'({1'b1, mb});
    e = int'(ea) + int'(eb) - 127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    if (e >= 255) return {4'b0001, s, 8'hFF, 23'h0};
    if (e <= 0) return {4'b0110, s, 31'h0};
    return {4'b0000, s, 8'(e), m};
  endfunction

  // Core model: LATENCY-stage pipeline advancing only when enabled.
  logic [35:0] pipe [LATENCY];
  initial for (int i = 0; i < LATENCY; i++) pipe[i] = '0;
  always @(posedge clk) begin
    if (mult_clk_en) begin
      for (int i = LATENCY - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= fmul(mult_dataa, mult_datab);
    end
  end
  assign {mult_status, mult_result} = pipe[LATENCY-1];

  // Count of non-hold edges; an op is due LATENCY of these after its grant.
  logic [31:0] adv = '0;
  always @(posedge clk) if (!hold) adv = adv + 32'd1;

  typedef struct packed {
    logic        id;
    logic [35:0] exp;
    logic [31:0] due;
  } sb_t;

  sb_t  sbq[$];
  logic rv_ids[$];

  // Scoreboard: pop/compare on rvalid, push on grant using bench-held operands.
  always @(negedge clk) begin
    sb_t e, ne;
    if (reset) begin
      sbq.delete();
    end else begin
      if (rvalid0 || rvalid1) begin
        total++;
        rv_ids.push_back(rvalid1);
        if (rvalid0 && rvalid1) begin
          $display("FAIL rvalid_both: rvalid0=%b rvalid1=%b required one-hot", rvalid0, rvalid1);
        end else if (sbq.size() == 0) begin
          $display("FAIL rvalid_unexpected: id=%b with no op outstanding", rvalid1);
        end else begin
          e = sbq.pop_front();
          if (rvalid1 !== e.id || {res_status, res} !== e.exp || adv !== e.due)
            $display("FAIL result: id=%b st=%h res=%h adv=%0d required id=%b st=%h res=%h adv=%0d",
                     rvalid1, res_status, res, adv, e.id, e.exp[35:32], e.exp[31:0], e.due);
          else
            passed++;
        end
      end
      if (gnt0 || gnt1) begin
        ne.id  = gnt1;
        ne.exp = gnt1 ? fmul(a1, b1) : fmul(a0, b0);
        ne.due = adv + 32'(LATENCY);
        sbq.push_back(ne);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      #1;
      if (sbq.size() == 0 && !busy) done = 1;
    end
    total++;
    if (!done) $display("FAIL drain: outstanding=%0d busy=%b required 0/0", sbq.size(), busy);
    else passed++;
    tick();
  endtask

  task automatic test_reset();
    reset = 1; hold = 0; req0 = 1; req1 = 1;
    a0 = 32'h3F800000; b0 = 32'h3F800000; a1 = 32'h3F800000; b1 = 32'h3F800000;
    tick(); tick();
    @(negedge clk);
    total++;
    if ({gnt0, gnt1} !== 2'b00) $display("FAIL reset_gnt: gnt=%b%b required 00", gnt0, gnt1);
    else passed++;
    total++;
    if (busy !== 1'b0 || {rvalid0, rvalid1} !== 2'b00)
      $display("FAIL reset_state: busy=%b rvalid=%b%b required 0 00", busy, rvalid0, rvalid1);
    else passed++;
    total++;
    if (mult_clk_en !== 1'b1) $display("FAIL reset_clk_en: got %b required 1", mult_clk_en);
    else passed++;
    tick();
    req0 = 0; req1 = 0; reset = 0;
  endtask

  task automatic test_single_op();
    req0 = 1; a0 = 32'h40000000; b0 = 32'h40400000;
    @(negedge clk);
    total++;
    if ({gnt0, gnt1} !== 2'b10 || mult_dataa !== 32'h40000000 || mult_datab !== 32'h40400000)
      $display("FAIL single_gnt: gnt=%b%b da=%h db=%h required 10 40000000 40400000",
               gnt0, gnt1, mult_dataa, mult_datab);
    else passed++;
    tick();
    req0 = 0; a0 = 32'h0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b1) $display("FAIL single_busy: cycle %0d busy=%b required 1", k, busy);
      else passed++;
      total++;
      if (k < 5) begin
        if ({rvalid0, rvalid1} !== 2'b00)
          $display("FAIL single_early: cycle %0d rvalid=%b%b required 00", k, rvalid0, rvalid1);
        else passed++;
      end else begin
        if ({rvalid0, rvalid1} !== 2'b10 || res !== 32'h40C00000 || res_status !== 4'b0000)
          $display("FAIL single_result: rvalid=%b%b res=%h st=%b required 10 40C00000 0000",
                   rvalid0, rvalid1, res, res_status);
        else passed++;
      end
      tick();
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL single_idle: busy=%b required 0", busy);
    else passed++;
    tick();
  endtask

  task automatic test_contention();
    logic expid;
    reset = 1; tick(); reset = 0;
    rv_ids.delete();
    req0 = 1; req1 = 1;
    a0 = 32'h40000000; b0 = 32'h40800000; a1 = 32'h40400000; b1 = 32'h40A00000;
    for (int c = 0; c < 4; c++) begin
`ifdef FPM_ARB_FIXED_PRIO_EN
      expid = 1'b0;
`else
      expid = 1'(c);
`endif
      @(negedge clk);
      total++;
      if ({gnt0, gnt1} !== {~expid, expid})
        $display("FAIL contention_gnt: cycle %0d gnt=%b%b required %b%b", c, gnt0, gnt1, ~expid, expid);
      else passed++;
      tick();
    end
    req0 = 0; req1 = 0;
    drain();
    total++;
`ifdef FPM_ARB_FIXED_PRIO_EN
    if (rv_ids.size() != 4 || rv_ids[0] || rv_ids[1] || rv_ids[2] || rv_ids[3])
`else
    if (rv_ids.size() != 4 || rv_ids[0] || !rv_ids[1] || rv_ids[2] || !rv_ids[3])
`endif
      $display("FAIL contention_order: got %0d results %p", rv_ids.size(), rv_ids);
    else passed++;
  endtask

  task automatic test_single_req();
    logic [1:0] expg [3];
    expg[0] = 2'b01; expg[1] = 2'b10;
`ifdef FPM_ARB_FIXED_PRIO_EN
    expg[2] = 2'b10;
`else
    expg[2] = 2'b01;
`endif
    a0 = 32'h3FC00000; b0 = 32'h40000000; a1 = 32'hC0000000; b1 = 32'h3F000000;
    for (int c = 0; c < 3; c++) begin
      req0 = (c != 0); req1 = 1;
      @(negedge clk);
      total++;
      if ({gnt0, gnt1} !== expg[c])
        $display("FAIL single_req_gnt: step %0d gnt=%b%b required %b", c, gnt0, gnt1, expg[c]);
      else passed++;
      tick();
    end
    req0 = 0; req1 = 0;
    drain();
  endtask

  task automatic test_back_to_back();
    req0 = 1;
    for (int c = 0; c < 6; c++) begin
      a0 = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
      b0 = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
      @(negedge clk);
      total++;
      if ({gnt0, gnt1} !== 2'b10) $display("FAIL b2b_gnt: cycle %0d gnt=%b%b required 10", c, gnt0, gnt1);
      else passed++;
      tick();
    end
    req0 = 0;
    drain();
  endtask

  task automatic test_hold();
    req1 = 1; a1 = 32'h40400000; b1 = 32'h40000000;
    @(negedge clk);
    total++;
    if ({gnt0, gnt1} !== 2'b01) $display("FAIL hold_issue: gnt=%b%b required 01", gnt0, gnt1);
    else passed++;
    tick();
    req1 = 0;
    tick();
    hold = 1; req0 = 1; a0 = 32'h3F800000; b0 = 32'h3F800000;
    for (int k = 2; k < 5; k++) begin
      @(negedge clk);
      total++;
      if ({gnt0, gnt1} !== 2'b00 || mult_clk_en !== 1'b0 || {rvalid0, rvalid1} !== 2'b00)
        $display("FAIL hold_freeze: cycle %0d gnt=%b%b clk_en=%b rvalid=%b%b required 00 0 00",
                 k, gnt0, gnt1, mult_clk_en, rvalid0, rvalid1);
      else passed++;
      tick();
    end
    hold = 0; req0 = 0;
    for (int k = 5; k <= 8; k++) begin
      @(negedge clk);
      total++;
      if (k < 8) begin
        if ({rvalid0, rvalid1} !== 2'b00)
          $display("FAIL hold_early: cycle %0d rvalid=%b%b required 00", k, rvalid0, rvalid1);
        else passed++;
      end else begin
        if ({rvalid0, rvalid1} !== 2'b01 || res !== 32'h40C00000)
          $display("FAIL hold_result: rvalid=%b%b res=%h required 01 40C00000", rvalid0, rvalid1, res);
        else passed++;
      end
      tick();
    end
    drain();
  endtask

  task automatic test_hold_tail();
    req0 = 1; a0 = 32'h41000000; b0 = 32'h3E800000;
    tick();
    req0 = 0;
    for (int k = 1; k < LATENCY; k++) tick();
    hold = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if ({rvalid0, rvalid1} !== 2'b00 || busy !== 1'b1)
        $display("FAIL tail_hold: step %0d rvalid=%b%b busy=%b required 00 1", k, rvalid0, rvalid1, busy);
      else passed++;
      tick();
    end
    hold = 0;
    @(negedge clk);
    total++;
    if ({rvalid0, rvalid1} !== 2'b10 || res !== 32'h40000000)
      $display("FAIL tail_release: rvalid=%b%b res=%h required 10 40000000", rvalid0, rvalid1, res);
    else passed++;
    tick();
    @(negedge clk);
    total++;
    if ({rvalid0, rvalid1} !== 2'b00 || busy !== 1'b0)
      $display("FAIL tail_once: rvalid=%b%b busy=%b required 00 0", rvalid0, rvalid1, busy);
    else passed++;
    tick();
  endtask

  task automatic test_special();
    req1 = 1; a1 = 32'h7F800000; b1 = 32'h00000000;
    tick();
    req1 = 0;
    for (int k = 1; k < LATENCY; k++) tick();
    @(negedge clk);
    total++;
    if ({rvalid0, rvalid1} !== 2'b01 || res_status[3] !== 1'b1)
      $display("FAIL special_nan: rvalid=%b%b st=%b required 01 1xxx", rvalid0, rvalid1, res_status);
    else passed++;
    tick();
    drain();
  endtask

  task automatic test_reset_midflight();
    req0 = 1;
    for (int c = 0; c < 3; c++) begin
      a0 = 32'h40000000 + 32'(c); b0 = 32'h40000000;
      tick();
    end
    req0 = 0;
    reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL midflight_busy: busy=%b required 0", busy);
    else passed++;
    for (int k = 0; k < 10; k++) begin
      total++;
      if ({rvalid0, rvalid1} !== 2'b00)
        $display("FAIL midflight_rvalid: cycle %0d rvalid=%b%b required 00", k, rvalid0, rvalid1);
      else passed++;
      @(negedge clk);
    end
    tick();
  endtask

  initial begin
    reset = 1; hold = 0; req0 = 0; req1 = 0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    test_reset();
    test_single_op();
    test_contention();
    test_single_req();
    test_back_to_back();
    test_hold();
    test_hold_tail();
    test_special();
    test_reset_midflight();
    total++;
    if (sbq.size() != 0) $display("FAIL leftover: %0d results never returned", sbq.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
